// File: rtl/spi_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : spi_pkg
//  Description : Shared types and constants for the SPI slave front-end:
//                FSM state encoding, frame command codes and default widths.
//  Revision    : 1.0  initial release
// ============================================================================
package spi_pkg;

    localparam int FRAME_W_DEFAULT = 10;
    localparam int DATA_W_DEFAULT  = 8;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        CHK_CMD   = 3'd1,
        WRITE     = 3'd2,
        READ_ADD  = 3'd3,
        READ_DATA = 3'd4
    } spi_state_t;

    localparam logic [1:0] CMD_WR_ADDR = 2'b00;
    localparam logic [1:0] CMD_WR_DATA = 2'b01;
    localparam logic [1:0] CMD_RD_ADDR = 2'b10;
    localparam logic [1:0] CMD_RD_DATA = 2'b11;

    // True for the states that shift in the remaining frame bits.
    function automatic logic is_data_state(input spi_state_t s);
        return (s == WRITE) || (s == READ_ADD) || (s == READ_DATA);
    endfunction

endpackage
`default_nettype wire

// File: rtl/spi_tx_serializer.sv
`default_nettype none
// ============================================================================
//  Module      : spi_tx_serializer
//  Description : MISO-side shifter. Loads a byte, presents its MSB on the same
//                edge and the remaining bits on the following edges, then
//                drives 0. Cleared by clr (slave deselect) or arst.
//  Ports       : clk, arst      - serial clock, async active-high reset
//                clr            - synchronous clear (ss_n high)
//                load, data     - byte load request and byte
//                miso           - registered serial output
//                busy           - bits still pending after the current one
//                done           - full byte has been presented
//  Revision    : 1.0  initial release
// ============================================================================
module spi_tx_serializer
    import spi_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEFAULT
) (
    input  logic              clk,
    input  logic              arst,
    input  logic              clr,
    input  logic              load,
    input  logic [DATA_W-1:0] data,
    output logic              miso,
    output logic              busy,
    output logic              done
);

    localparam int CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;

    logic [DATA_W-1:0] shreg;
    logic [CNT_W-1:0]  remaining;

    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            shreg     <= '0;
            remaining <= '0;
            miso      <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else if (clr) begin
            shreg     <= '0;
            remaining <= '0;
            miso      <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else if (load) begin
            // MSB goes out immediately; the rest waits in shreg.
            miso      <= data[DATA_W-1];
            shreg     <= data << 1;
            remaining <= CNT_W'(DATA_W - 1);
            busy      <= (DATA_W > 1);
            done      <= (DATA_W == 1);
        end else if (busy) begin
            miso      <= shreg[DATA_W-1];
            shreg     <= shreg << 1;
            remaining <= remaining - CNT_W'(1);
            // busy drops on the edge that presents the final bit.
            if (remaining == CNT_W'(1)) begin
                busy <= 1'b0;
                done <= 1'b1;
            end
        end else begin
            miso <= 1'b0;
        end
    end

endmodule
`default_nettype wire

// File: rtl/spi_slave_if.sv
`default_nettype none
// ============================================================================
//  Module      : spi_slave_if
//  Description : SPI slave front-end for the single-port RAM. Deserialises
//                MOSI frames {cmd[1:0], payload[7:0]} into rx_data with a
//                one-cycle rx_valid strobe, and on a read-data transaction
//                serialises the returned RAM byte onto MISO, MSB first.
//                clk is the SPI serial clock (rising edge only).
//  Ports       : clk, arst         - SPI clock, async active-high reset
//                ss_n              - slave select, active-low
//                mosi / miso       - serial data in / out
//                rx_data, rx_valid - assembled frame and its strobe
//                tx_data, tx_valid - RAM read byte and its valid
//                frame_err         - abort pulse (only with SPI_FRAME_ERR_EN)
//  Options     : `define SPI_FRAME_ERR_EN adds the frame_err output.
//  Revision    : 1.0  initial release
// ============================================================================
module spi_slave_if
    import spi_pkg::*;
#(
    parameter int FRAME_W = FRAME_W_DEFAULT,
    parameter int DATA_W  = DATA_W_DEFAULT
) (
    input  logic               clk,
    input  logic               arst,
    input  logic               ss_n,
    input  logic               mosi,
    output logic               miso,
    output logic [FRAME_W-1:0] rx_data,
    output logic               rx_valid,
    input  logic [DATA_W-1:0]  tx_data,
    input  logic               tx_valid
`ifdef SPI_FRAME_ERR_EN
    ,
    output logic               frame_err
`endif
);

    localparam int CNT_W = $clog2(FRAME_W + 1);

    spi_state_t         state;
    spi_state_t         state_next;
    logic [CNT_W-1:0]   bit_cnt;
    logic [FRAME_W-2:0] shift_reg;
    logic               rd_addr_held;

    logic               frame_last;
    logic               frame_done;
    logic [1:0]         frame_cmd;
    logic               ser_load;
    logic               ser_busy;
    logic               ser_done;

    // frame_last: this edge captures the final bit. frame_done: all bits in,
    // further MOSI bits are ignored until deselect.
    assign frame_last = (bit_cnt == CNT_W'(FRAME_W - 1));
    assign frame_done = (bit_cnt == CNT_W'(FRAME_W));
    // Once FRAME_W-1 bits are shifted in, the command sits at the top.
    assign frame_cmd  = shift_reg[FRAME_W-2 -: 2];

    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        if (ss_n) begin
            state_next = IDLE;
        end else begin
            case (state)
                IDLE:    state_next = CHK_CMD;
                CHK_CMD: begin
                    if (!mosi) begin
                        state_next = WRITE;
                    end else if (rd_addr_held) begin
                        state_next = READ_DATA;
                    end else begin
                        state_next = READ_ADD;
                    end
                end
                WRITE, READ_ADD, READ_DATA: state_next = state;
                default: state_next = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            bit_cnt      <= '0;
            shift_reg    <= '0;
            rx_data      <= '0;
            rx_valid     <= 1'b0;
            rd_addr_held <= 1'b0;
        end else begin
            rx_valid <= 1'b0;
            if (ss_n) begin
                bit_cnt <= '0;
            end else if (state == CHK_CMD) begin
                shift_reg <= {shift_reg[FRAME_W-3:0], mosi};
                bit_cnt   <= CNT_W'(1);
            end else if (is_data_state(state) && !frame_done) begin
                shift_reg <= {shift_reg[FRAME_W-3:0], mosi};
                bit_cnt   <= bit_cnt + CNT_W'(1);
                if (frame_last) begin
                    rx_data  <= {shift_reg, mosi};
                    rx_valid <= 1'b1;
                    if (frame_cmd == CMD_RD_ADDR) begin
                        rd_addr_held <= 1'b1;
                    end else if (frame_cmd == CMD_RD_DATA) begin
                        rd_addr_held <= 1'b0;
                    end
                end
            end
        end
    end

    // Only the first tx_valid after a completed read-data frame is taken.
    assign ser_load = (state == READ_DATA) && frame_done && tx_valid
                      && !ser_busy && !ser_done;

    spi_tx_serializer #(
        .DATA_W (DATA_W)
    ) u_tx_ser (
        .clk  (clk),
        .arst (arst),
        .clr  (ss_n),
        .load (ser_load),
        .data (tx_data),
        .miso (miso),
        .busy (ser_busy),
        .done (ser_done)
    );

`ifdef SPI_FRAME_ERR_EN
    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            frame_err <= 1'b0;
        end else begin
            frame_err <= ss_n && ((is_data_state(state) && !frame_done) || ser_busy);
        end
    end
`endif

endmodule
`default_nettype wire

// File: tb/tb_spi_slave_if.sv
`default_nettype none
// ============================================================================
//  Module      : tb_spi_slave_if
//  Description : Self-checking bench for spi_slave_if. Directed table of
//                transactions followed by randomized transactions, all
//                checked per edge against a transaction-level model.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_spi_slave_if;
    import spi_pkg::*;

    logic       clk      = 1'b0;
    logic       arst     = 1'b0;
    logic       ss_n     = 1'b1;
    logic       mosi     = 1'b0;
    logic       tx_valid = 1'b0;
    logic [7:0] tx_data  = 8'h00;
    logic       miso;
    logic       rx_valid;
    logic [9:0] rx_data;
`ifdef SPI_FRAME_ERR_EN
    logic       frame_err;
`endif

    spi_slave_if dut (
        .clk      (clk),
        .arst     (arst),
        .ss_n     (ss_n),
        .mosi     (mosi),
        .miso     (miso),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .tx_data  (tx_data),
        .tx_valid (tx_valid)
`ifdef SPI_FRAME_ERR_EN
        ,
        .frame_err(frame_err)
`endif
    );

    always #5 clk = ~clk;

    int         n_tests = 0;
    int         n_fail  = 0;
    logic       m_held  = 1'b0;
    logic [9:0] m_rx    = 10'h000;

    task automatic check(input string name, input int idx, input logic [31:0] act,
                         input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s idx=%0d got=%h expected=%h", name, idx, act, exp);
        end
    endtask

    task automatic check_reset_outputs(input int idx);
        check("rst_rx_valid", idx, rx_valid, 1'b0);
        check("rst_rx_data", idx, rx_data, 10'h000);
        check("rst_miso", idx, miso, 1'b0);
        check("rst_state", idx, dut.state, IDLE);
        check("rst_held", idx, dut.rd_addr_held, 1'b0);
`ifdef SPI_FRAME_ERR_EN
        check("rst_frame_err", idx, frame_err, 1'b0);
`endif
    endtask

    // One transaction: ss_n low for len edges (edge 0 is the start cycle),
    // then one deselect edge and one idle edge. tv is the first edge whose
    // sampled tx_valid is 1 (-1: never). rst_at >= 0 asserts arst right after
    // that edge and ends the transaction.
    task automatic run_txn(input logic [9:0] f, input int len, input int tv,
                           input logic [7:0] tx, input int rst_at,
                           output int pulses, output logic [9:0] last_rx,
                           output logic [7:0] obs_byte);
        logic       is_rd;
        logic       complete;
        int         ld;
        logic [9:0] prev;
        logic       exp_miso;
        logic       exp_err;
        is_rd    = f[9] && m_held;
        complete = (len >= 11);
        ld       = (is_rd && complete && tv >= 11 && tv < len) ? tv : -1;
        prev     = m_rx;
        pulses   = 0;
        obs_byte = 8'h00;
        for (int k = 0; k < len; k++) begin
            ss_n     = 1'b0;
            mosi     = (k >= 1 && k <= 10) ? f[10-k] : 1'($urandom);
            tx_valid = is_rd ? (tv >= 0 && k >= tv) : 1'($urandom);
            tx_data  = (k == ld) ? tx : 8'($urandom);
            @(posedge clk);
            #1;
            exp_miso = (ld >= 0 && k >= ld && k <= ld + 7) ? tx[7-(k-ld)] : 1'b0;
            check("rx_valid", k, rx_valid, (k == 10));
            check("rx_data", k, rx_data, (k >= 10) ? f : prev);
            check("miso", k, miso, exp_miso);
`ifdef SPI_FRAME_ERR_EN
            check("frame_err_low", k, frame_err, 1'b0);
`endif
            if (rx_valid === 1'b1) pulses++;
            if (k >= 12 && k <= 19) obs_byte[19-k] = miso;
            if (k == rst_at) begin
                #2;
                arst = 1'b1;
                #1;
                check_reset_outputs(k);
                ss_n     = 1'b1;
                tx_valid = 1'b0;
                #1;
                arst = 1'b0;
                m_held = 1'b0;
                m_rx   = 10'h000;
                @(posedge clk);
                #1;
                last_rx = rx_data;
                return;
            end
        end
        // Deselect edge.
        ss_n     = 1'b1;
        mosi     = 1'($urandom);
        tx_valid = 1'($urandom);
        tx_data  = 8'($urandom);
        @(posedge clk);
        #1;
        exp_err = (len >= 2 && len <= 10) || (ld >= 0 && ld <= len - 1 && len <= ld + 7);
        check("desel_rx_valid", len, rx_valid, 1'b0);
        check("desel_miso", len, miso, 1'b0);
        check("desel_rx_data", len, rx_data, complete ? f : prev);
        check("desel_state", len, dut.state, IDLE);
`ifdef SPI_FRAME_ERR_EN
        check("frame_err", len, frame_err, exp_err);
`endif
        if (complete) begin
            m_rx = f;
            if (f[9:8] == 2'b10) m_held = 1'b1;
            else if (f[9:8] == 2'b11) m_held = 1'b0;
        end
        check("held", len, dut.rd_addr_held, m_held);
        // Idle edge, still deselected.
        @(posedge clk);
        #1;
        check("idle_miso", len + 1, miso, 1'b0);
`ifdef SPI_FRAME_ERR_EN
        check("idle_frame_err", len + 1, frame_err, 1'b0);
`endif
        last_rx = rx_data;
    endtask

    typedef struct {
        logic [9:0] frame;
        int         len;
        int         tv;
        logic [7:0] tx;
        int         rst_at;
        logic [9:0] exp_rx;
        int         exp_pulses;
        logic [7:0] exp_byte;
        logic       exp_held;
    } vec_t;

    vec_t vecs[15];

    initial begin
        int         pulses;
        logic [9:0] last_rx;
        logic [7:0] obs;

        //           frame   len tv  tx     rst  exp_rx  pls byte   held
        vecs[0]  = '{10'h0A5, 12, -1, 8'h00, -1, 10'h0A5, 1, 8'h00, 1'b0}; // write addr
        vecs[1]  = '{10'h13C, 12, -1, 8'h00, -1, 10'h13C, 1, 8'h00, 1'b0}; // write data
        vecs[2]  = '{10'h207, 12, -1, 8'h00, -1, 10'h207, 1, 8'h00, 1'b1}; // read addr
        vecs[3]  = '{10'h35A, 20, 12, 8'hC3, -1, 10'h35A, 1, 8'hC3, 1'b0}; // read data
        vecs[4]  = '{10'h3FF, 20, 12, 8'h5A, -1, 10'h3FF, 1, 8'h00, 1'b0}; // cmd11, held=0
        vecs[5]  = '{10'h0AA,  6, -1, 8'h00, -1, 10'h3FF, 0, 8'h00, 1'b0}; // abort 5 bits
        vecs[6]  = '{10'h2F0, 12, -1, 8'h00, -1, 10'h2F0, 1, 8'h00, 1'b1};
        vecs[7]  = '{10'h301, 30, -1, 8'hC3, -1, 10'h301, 1, 8'h00, 1'b0}; // no response
        vecs[8]  = '{10'h2F0, 12, -1, 8'h00, -1, 10'h2F0, 1, 8'h00, 1'b1};
        vecs[9]  = '{10'h3AB, 16, 12, 8'hC3, -1, 10'h3AB, 1, 8'hC0, 1'b0}; // abort mid-byte
        vecs[10] = '{10'h2F0, 12, -1, 8'h00, -1, 10'h2F0, 1, 8'h00, 1'b1};
        vecs[11] = '{10'h3CD, 24, 15, 8'hA5, -1, 10'h3CD, 1, 8'h14, 1'b0}; // late tx_valid
        vecs[12] = '{10'h155, 14, -1, 8'h00, 10, 10'h000, 1, 8'h00, 1'b0}; // arst after strobe
        vecs[13] = '{10'h2F0, 12, -1, 8'h00, -1, 10'h2F0, 1, 8'h00, 1'b1};
        vecs[14] = '{10'h3CD, 20, 12, 8'hC3, 13, 10'h000, 1, 8'hC0, 1'b0}; // arst mid-byte

        // Reset applied before any clock edge must act on its own.
        #1;
        arst = 1'b1;
        #1;
        check_reset_outputs(-1);
        repeat (2) @(posedge clk);
        #1;
        arst = 1'b0;
        @(posedge clk);
        #1;
        check("idle_after_reset", 0, dut.state, IDLE);

        foreach (vecs[i]) begin
            run_txn(vecs[i].frame, vecs[i].len, vecs[i].tv, vecs[i].tx, vecs[i].rst_at,
                    pulses, last_rx, obs);
            check("tbl_rx_data", i, last_rx, vecs[i].exp_rx);
            check("tbl_pulses", i, pulses, vecs[i].exp_pulses);
            check("tbl_miso_byte", i, obs, vecs[i].exp_byte);
            check("tbl_held", i, dut.rd_addr_held, vecs[i].exp_held);
        end

        for (int n = 0; n < 200; n++) begin
            logic [9:0] f;
            int         len;
            int         tv;
            f   = 10'($urandom);
            // Favour read-address frames so read-data transactions are common.
            if (($urandom % 3) == 0) f[9:8] = 2'b10;
            len = $urandom_range(1, 24);
            tv  = (($urandom % 4) == 0) ? -1 : $urandom_range(11, 16);
            run_txn(f, len, tv, 8'($urandom), -1, pulses, last_rx, obs);
            check("rnd_pulses", n, pulses, (len >= 11) ? 1 : 0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog time limit reached got=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire

// File: doc/spi_slave_if.md
Name: spi_slave_if

Overview:
- SPI slave front-end directly upstream of the single-port RAM.
- Deserialises MOSI frames into 10-bit words and presents them with a one-cycle rx_valid strobe.
- On a read-data command, it captures the RAM's returned byte on tx_valid and serialises it onto MISO, MSB first.
- clk is the SPI serial clock; all sampling and driving happens on its rising edge.

Parameters:
- FRAME_W, 10: received word width (2 command bits + 8 payload bits).
- DATA_W, 8: width of the RAM read byte shifted out on MISO.

Ports:
- clk  input  1  SPI serial clock; all logic on rising edge.
- arst  input  1  asynchronous reset, active-high.
- ss_n  input  1  slave select, active-low; high aborts any frame.
- mosi  input  1  serial data in, MSB first.
- miso  output  1  serial data out, MSB first.
- rx_data  output  FRAME_W  assembled frame {cmd[1:0], payload[7:0]} to the RAM din.
- rx_valid  output  1  one-cycle strobe marking rx_data valid.
- tx_data  input  DATA_W  RAM read byte.
- tx_valid  input  1  RAM read byte valid.

Behaviour:
- Reset: arst=1 asynchronously forces the following; all hold until the first rising edge after arst falls.
  - state=IDLE.
  - rx_data=0, rx_valid=0, miso=0.
  - bit counter=0, rd_addr_held=0.
- States: IDLE, CHK_CMD, WRITE, READ_ADD, READ_DATA.
- ss_n=1 sampled in any state: next state is IDLE and the bit counter clears.
  - No rx_valid for a partial frame.
  - miso drives 0.
  - rd_addr_held is unchanged.
- IDLE: ss_n=0 sampled -> CHK_CMD. mosi is ignored on this edge (start cycle).
- CHK_CMD: mosi is sampled as frame bit 9 and stored in the shift register; counter=1.
  - mosi=0 -> WRITE.
  - mosi=1 and rd_addr_held=0 -> READ_ADD.
  - mosi=1 and rd_addr_held=1 -> READ_DATA.
- WRITE / READ_ADD / READ_DATA: one bit is shifted in per edge.
  - On the edge capturing bit 0 (the 10th bit): rx_data <= {shift[8:0], mosi} and rx_valid <= 1.
  - rx_valid falls on the following edge.
  - Bits are forwarded raw; the FSM never rewrites the cmd bits.
- After a completed frame, further mosi bits are ignored until ss_n=1.
- rd_addr_held:
  - Set on a completed frame with cmd=2'b10.
  - Cleared on a completed frame with cmd=2'b11.
  - Other frames leave it unchanged.
- READ_DATA timing, where the 10th bit is captured at edge N:
  - The RAM responds with tx_valid at edge N+1.
  - At the first edge where tx_valid=1 is sampled (nominally N+2), tx_data loads the output register and miso=tx_data[7].
  - Bits 6..0 follow on the next 7 edges.
  - miso then returns to 0 and stays there until ss_n=1.
- tx_valid is ignored outside READ_DATA, and ignored once serialisation has started.
- If tx_valid never arrives, the block waits in READ_DATA until ss_n=1.
- ss_n=1 during miso serialisation aborts it; miso=0 on the next edge.
- Minimum ss_n-low duration:
  - Write or read-address transaction: 12 clocks.
  - Read-data transaction: 20 clocks.

Optional Feature:
- Macro: SPI_FRAME_ERR_EN.
- When defined, adds output port frame_err (1 bit, reset 0).
  - Pulses high for one cycle when ss_n=1 is sampled while in WRITE, READ_ADD or READ_DATA before the 10th bit has been captured.
  - Also pulses when ss_n=1 is sampled mid-serialisation of the read byte.
- When undefined, the port and its logic are absent; abort behaviour is otherwise identical.

Decomposition:
- Package spi_pkg holds:
  - State encoding localparams (IDLE, CHK_CMD, WRITE, READ_ADD, READ_DATA).
  - Command constants: CMD_WR_ADDR=2'b00, CMD_WR_DATA=2'b01, CMD_RD_ADDR=2'b10, CMD_RD_DATA=2'b11.
  - FRAME_W and DATA_W defaults.
- One sub-module, spi_tx_serializer, is natural for the MISO side.
  - Loads on tx_valid, shifts 8 bits MSB first, exposes a busy/done flag.
  - Clears on ss_n=1 or arst.

Test Plan:
- Reset: assert arst mid-frame with ss_n=0 -> rx_valid=0, miso=0, state IDLE immediately, without a clock edge.
- Write address: ss_n low, start cycle, then bits 00_1010_0101 -> one rx_valid pulse with rx_data=10'h0A5; no MISO activity.
- Write data: frame 01_0011_1100 -> rx_data=10'h13C, rx_valid high for exactly 1 cycle.
- Read sequence:
  - Frame 10_0000_0111 (rx_data=10'h207) -> rd_addr_held=1.
  - Next frame 11_xxxx_xxxx enters READ_DATA.
  - Model tx_valid with tx_data=8'hC3 one cycle after rx_valid -> miso=1,1,0,0,0,0,1,1 on 8 consecutive edges; rd_addr_held=0 afterwards.
- Abort: ss_n=1 after 5 bits of a write frame -> no rx_valid, state IDLE; with SPI_FRAME_ERR_EN, frame_err pulses once.
- Read with no response: READ_DATA frame with tx_valid held 0 -> miso stays 0; FSM exits to IDLE only when ss_n=1.
